demux_stream: RTL
=================

# demux_stream

Registered 1:2 stream demultiplexer: the steering counterpart to the team's 2:1 selector `mux`. Accepts one WIDTH-bit word per cycle on a valid/ready input and routes it, according to `in_sel`, into one of two single-entry output channels (A for sel=0, B for sel=1). Each channel has its own valid/ready handshake. The block sits between a shared producer and two independent consumers.

## Interface
- `WIDTH`, default 3: data width of input and both output channels.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination: 0 → channel A, 1 → channel B.
- `in_valid`  in  1  input word and sel valid.
- `in_ready`  out  1  block can accept this cycle.
- `a_data`  out  WIDTH  channel A word.
- `a_valid`  out  1  channel A holds a word.
- `a_ready`  in  1  channel A consumer accepts.
- `b_data`  out  WIDTH  channel B word.
- `b_valid`  out  1  channel B holds a word.
- `b_ready`  in  1  channel B consumer accepts.
- `a_count`  out  8  channel A delivered-word count; present only with `DEMUX_COUNT_EN`.
- `b_count`  out  8  channel B delivered-word count; present only with `DEMUX_COUNT_EN`.

## Operation
- Each channel is one register slot with state EMPTY (valid=0) or FULL (valid=1).
- Slot transitions:
  - EMPTY → FULL on fill.
  - FULL → EMPTY on drain without fill.
  - FULL → FULL on drain and fill in the same cycle; the register reloads with the new word.
- Drain: `x_valid && x_ready`. Fill: input handshake with `in_sel` selecting x.
- `in_ready = !x_valid || x_ready`, where x is the channel selected by the current `in_sel`. This is combinational from `in_sel`, `a_valid`/`b_valid` and `a_ready`/`b_ready`. The non-selected channel has no effect on it.
- Input handshake: `in_valid && in_ready`. `in_data` and `in_sel` are sampled only on the handshake edge.
- A full, stalled channel B never blocks words destined for A, and vice versa.
- While `x_valid=1 && x_ready=0`, `x_data` is held stable.
- Ordering is preserved per channel. No ordering is implied between A and B.
- Output data register is loaded only on fill. Its value while valid=0 is don't-care for consumers, but must be 0 after reset.

## Timing
- Reset (edge with `rst=1`): `a_valid=b_valid=0`, `a_data=b_data=0`, counters 0.
- `in_ready` is 1 in the first cycle after reset.
- Reset mid-operation discards held words. No handshake completes on a reset edge.
- Latency: word accepted at edge N is visible on `x_data`/`x_valid` from just after edge N; it can be consumed at edge N+1 at the earliest.
- Throughput: 1 word/cycle per channel with consumer ready held high. Alternating sel also gives 1 word/cycle.
- Boundary: slot FULL and `x_ready=0` → `in_ready=0` for sel=x. With `in_valid=1` the input must hold; the block does not drop data.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - `a_count` and `b_count` ports exist.
  - Each increments by 1 on its channel's drain handshake and wraps 255 → 0.
  - Both reset to 0.
- `DEMUX_COUNT_EN` undefined: counter ports and logic are absent. Data-path behaviour is identical.

## Structure
- Package `demux_pkg`:
  - `DEMUX_WIDTH_DEFAULT = 3`.
  - Channel typedef `demux_ch_t` with `CH_A = 1'b0`, `CH_B = 1'b1`.
  - Counter width constant `DEMUX_CNT_W = 8`.
- Sub-module `demux_slot`: one-entry register slot.
  - Ports: `clk`, `rst`, `fill`, `fill_data`, `out_data`, `out_valid`, `out_ready`, `can_fill`.
  - Optional counter under the same macro.
  - Instantiated twice by `demux_stream`.

## Test plan
- Reset, then `in_valid=1`, `in_sel=0`, `in_data=3'b101`, `a_ready=1` → `a_valid=1`, `a_data=3'b101` after one edge; `b_valid` stays 0.
- `a_ready=0`; send 3'b011 to A, then 3'b110 to A → second word stalls with `in_ready=0`; `a_data` holds 3'b011. Raise `a_ready` → 3'b011 then 3'b110 delivered in order.
- A stalled with 3'b001 held; send 3'b111 with `in_sel=1`, `b_ready=1` → `in_ready=1`, B delivers 3'b111; A still holds 3'b001.
- Both ready; stream 3'b000–3'b111 alternating sel → 8 consecutive accepts with no bubbles; A gets the even-index words, B the odd-index words.
- Fill both slots, assert `rst` for one cycle → `a_valid=b_valid=0`, data 0, `in_ready=1` on the next cycle.
- With `DEMUX_COUNT_EN`: deliver 257 words to A → `a_count=1` (wrapped), `b_count=0`. Without the macro, the bench compiles without counter ports.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:2 stream demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_WIDTH_DEFAULT = 3;
    localparam int unsigned DEMUX_CNT_W = 8;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } demux_ch_t;

endpackage

// File: rtl/demux_stream_if.sv
// Producer-side input stream plus the two consumer channels of demux_stream.
interface demux_stream_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    // Environment side: producer and both consumers.
    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry output register slot; optional drain counter under DEMUX_COUNT_EN.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill,
    input  logic [WIDTH-1:0]       fill_data,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   can_fill
`ifdef DEMUX_COUNT_EN
    ,
    output logic [DEMUX_CNT_W-1:0] count
`endif
);
    logic drain;

    assign drain    = out_valid && out_ready;
    assign can_fill = !out_valid || out_ready;

    // Fill wins over drain so a simultaneous drain+fill reloads and stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fill) begin
            out_valid <= 1'b1;
            out_data  <= fill_data;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (drain) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_stream.sv
// Registered 1:2 stream demultiplexer; in_sel steers each word to slot A or B.
// Optional per-channel delivered-word counters under DEMUX_COUNT_EN.
module demux_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_stream_if.slave          bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [DEMUX_CNT_W-1:0] a_count,
    output logic [DEMUX_CNT_W-1:0] b_count
`endif
);
    demux_ch_t sel;
    logic      a_can_fill;
    logic      b_can_fill;
    logic      accept;
    logic      a_fill;
    logic      b_fill;

    assign sel = demux_ch_t'(bus.in_sel);

    // Only the selected slot gates acceptance, so a stalled peer never blocks.
    assign bus.in_ready = (sel == CH_B) ? b_can_fill : a_can_fill;
    assign accept       = bus.in_valid && bus.in_ready;
    assign a_fill       = accept && (sel == CH_A);
    assign b_fill       = accept && (sel == CH_B);

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .fill      (a_fill),
        .fill_data (bus.in_data),
        .out_data  (bus.a_data),
        .out_valid (bus.a_valid),
        .out_ready (bus.a_ready),
        .can_fill  (a_can_fill)
`ifdef DEMUX_COUNT_EN
        ,
        .count     (a_count)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .fill      (b_fill),
        .fill_data (bus.in_data),
        .out_data  (bus.b_data),
        .out_valid (bus.b_valid),
        .out_ready (bus.b_ready),
        .can_fill  (b_can_fill)
`ifdef DEMUX_COUNT_EN
        ,
        .count     (b_count)
`endif
    );

endmodule
